// File: rtl/sr_task_queue_ctrl.sv
// Task-queue controller: a single-command FSM that sequences enqueue, dequeue,
// block and activate operations onto a row of shift-register queue cells. It
// keeps the occupancy count and hands dequeued task ids out on a dispatch port.
//
// Handshakes: a transfer happens on the rising edge where valid && ready are
// both 1. The source holds valid and its payload until that edge. The sink's
// ready may depend on its own state only.
module sr_task_queue_ctrl #(
  parameter int DEPTH  = 8,
  parameter int TID_W  = 4,
  parameter int INFO_W = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [TID_W-1:0]  cmd_tid,
  input  logic [INFO_W-1:0] cmd_info,
  input  logic [TID_W-1:0]  head_tid,
  output logic              enqueue,
  output logic              dequeue,
  output logic              remove,
  output logic              que_act,
  output logic              que_blk,
  output logic [TID_W-1:0]  in_tid,
  output logic [INFO_W-1:0] parallel_data,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [TID_W-1:0]  disp_tid,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              err,
  output logic [1:0]        fsm_state
);

  localparam logic [1:0] OP_ENQ = 2'b00;
  localparam logic [1:0] OP_DEQ = 2'b01;
  localparam logic [1:0] OP_BLK = 2'b10;
  localparam logic [1:0] OP_ACT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_SETTLE = 2'd2,
    S_DISP   = 2'd3
  } state_t;

  state_t     state, state_n;
  logic [1:0] op_q;
  logic       accept;

  assign accept     = (state == S_IDLE) && cmd_valid;
  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign disp_valid = (state == S_DISP);
  assign fsm_state  = state;

  // State register; reset aborts any operation in flight, including a dispatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state and the one-cycle cell strobes, which fire only in EXEC.
  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    enqueue   = 1'b0;
    dequeue   = 1'b0;
    remove    = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_n = S_EXEC;
      end
      S_EXEC: begin
        state_n = S_SETTLE;
        case (op_q)
          OP_ENQ: begin
            if (full) err = 1'b1;
            else      enqueue = 1'b1;
          end
          OP_DEQ: begin
            if (empty) begin
              err = 1'b1;
            end else begin
              dequeue = 1'b1;
              // Last entry leaving: cells also clear their valid flags.
              remove  = (count == CNT_W'(1));
              state_n = S_DISP;
            end
          end
          default: ;
        endcase
      end
      S_SETTLE: state_n = S_IDLE;
      S_DISP: begin
        if (disp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Capture the accepted command and its payload; payload regs hold until replaced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q          <= OP_ENQ;
      in_tid        <= '0;
      parallel_data <= '0;
      disp_tid      <= '0;
    end else if (accept) begin
      op_q <= cmd_op;
      if (cmd_op == OP_ENQ) begin
        in_tid        <= cmd_tid;
        parallel_data <= cmd_info;
      end
      if (cmd_op == OP_DEQ && !empty) disp_tid <= head_tid;
    end
  end

  // Occupancy count follows the strobes, so it can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          count <= '0;
    else if (enqueue) count <= count + CNT_W'(1);
    else if (dequeue) count <= count - CNT_W'(1);
  end

  // Queue-state levels; block and activate are mutually exclusive by construction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      que_act <= 1'b0;
      que_blk <= 1'b1;
    end else if (state == S_EXEC && op_q == OP_BLK) begin
      que_act <= 1'b0;
      que_blk <= 1'b1;
    end else if (state == S_EXEC && op_q == OP_ACT) begin
      que_act <= 1'b1;
      que_blk <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sr_task_queue_ctrl.sv
// Self-checking bench for sr_task_queue_ctrl. The reference model treats the
// cell row as a FIFO of task ids (exp_q) and tracks the queue-state levels and
// the last enqueue payload. The bench drives head_tid from the model's front.
module tb_sr_task_queue_ctrl;

  localparam int DEPTH  = 8;
  localparam int TID_W  = 4;
  localparam int INFO_W = 32;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'b00;
  logic [TID_W-1:0]  cmd_tid = '0;
  logic [INFO_W-1:0] cmd_info = '0;
  logic [TID_W-1:0]  head_tid = '0;
  logic              enqueue, dequeue, remove, que_act, que_blk;
  logic [TID_W-1:0]  in_tid;
  logic [INFO_W-1:0] parallel_data;
  logic              disp_valid;
  logic              disp_ready = 1'b0;
  logic [TID_W-1:0]  disp_tid;
  logic [CNT_W-1:0]  count;
  logic              full, empty, err;
  logic [1:0]        fsm_state;

  sr_task_queue_ctrl #(.DEPTH(DEPTH), .TID_W(TID_W), .INFO_W(INFO_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_tid(cmd_tid), .cmd_info(cmd_info), .head_tid(head_tid),
    .enqueue(enqueue), .dequeue(dequeue), .remove(remove),
    .que_act(que_act), .que_blk(que_blk),
    .in_tid(in_tid), .parallel_data(parallel_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_tid(disp_tid),
    .count(count), .full(full), .empty(empty), .err(err),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [TID_W-1:0]  exp_q[$];
  logic              m_act = 1'b0;
  logic              m_blk = 1'b1;
  logic [TID_W-1:0]  m_in_tid = '0;
  logic [INFO_W-1:0] m_info = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_act    = 1'b0;
    m_blk    = 1'b1;
    m_in_tid = '0;
    m_info   = '0;
  endtask

  task automatic check_levels(input string tag);
    chk({tag, "_count"}, 32'(count), exp_q.size());
    chk({tag, "_full"},  32'(full),  32'(exp_q.size() == DEPTH));
    chk({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
    chk({tag, "_act"},   32'(que_act), 32'(m_act));
    chk({tag, "_blk"},   32'(que_blk), 32'(m_blk));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    disp_ready = 1'b0;
    @(negedge clk);
    model_reset();
    chk("rst_strobes", 32'({enqueue, dequeue, remove, err, disp_valid}), 0);
    chk("rst_payload", 32'(in_tid) | 32'(disp_tid) | 32'(parallel_data), 0);
    check_levels("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 1);
  endtask

  // Issue one command from IDLE (at a negedge) and follow it back to IDLE.
  task automatic run_cmd(input logic [1:0] op, input logic [TID_W-1:0] tid,
                         input logic [INFO_W-1:0] info, input int wait_cyc);
    bit was_full, was_empty, exp_enq, exp_deq, exp_rem, exp_err;
    logic [TID_W-1:0] exp_disp;
    exp_disp = '0;
    chk("idle_ready", 32'(cmd_ready), 1);
    head_tid  = (exp_q.size() > 0) ? exp_q[0] : '0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_tid   = tid;
    cmd_info  = info;
    was_full  = (exp_q.size() == DEPTH);
    was_empty = (exp_q.size() == 0);
    exp_enq   = (op == 2'b00) && !was_full;
    exp_deq   = (op == 2'b01) && !was_empty;
    exp_rem   = exp_deq && (exp_q.size() == 1);
    exp_err   = ((op == 2'b00) && was_full) || ((op == 2'b01) && was_empty);
    @(negedge clk);  // EXEC
    cmd_valid = 1'b0;
    cmd_tid   = TID_W'($urandom());
    chk("exec_ready", 32'(cmd_ready), 0);
    chk("exec_enqueue", 32'(enqueue), 32'(exp_enq));
    chk("exec_dequeue", 32'(dequeue), 32'(exp_deq));
    chk("exec_remove",  32'(remove),  32'(exp_rem));
    chk("exec_err",     32'(err),     32'(exp_err));
    case (op)
      2'b00: begin
        m_in_tid = tid;
        m_info   = info;
        if (!was_full) exp_q.push_back(tid);
      end
      2'b01: if (!was_empty) exp_disp = exp_q.pop_front();
      2'b10: begin m_blk = 1'b1; m_act = 1'b0; end
      default: begin m_act = 1'b1; m_blk = 1'b0; end
    endcase
    @(negedge clk);  // SETTLE or DISP
    chk("post_strobes", 32'({enqueue, dequeue, remove, err}), 0);
    check_levels("post");
    chk("post_in_tid", 32'(in_tid), 32'(m_in_tid));
    chk("post_info",   32'(parallel_data), 32'(m_info));
    if (exp_deq) begin
      for (int n = 0; n < wait_cyc; n++) begin
        chk("disp_valid_hold", 32'(disp_valid), 1);
        chk("disp_tid_hold",   32'(disp_tid),   32'(exp_disp));
        chk("disp_ready_low",  32'(cmd_ready),  0);
        cmd_valid = 1'b1;  // must be ignored outside IDLE
        cmd_op    = 2'($urandom_range(0, 3));
        @(negedge clk);
      end
      cmd_valid  = 1'b0;
      disp_ready = 1'b1;
      chk("disp_valid_last", 32'(disp_valid), 1);
      chk("disp_tid_last",   32'(disp_tid),   32'(exp_disp));
      @(negedge clk);
      disp_ready = 1'b0;
    end else begin
      chk("no_dispatch", 32'(disp_valid), 0);
      @(negedge clk);
    end
    chk("back_idle_valid", 32'(disp_valid), 0);
    chk("back_idle_strb", 32'({enqueue, dequeue, remove, err}), 0);
    check_levels("idle");
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [1:0] op;
    int r;
    @(negedge clk);
    do_reset();

    // activate, then enqueue tid=3 info=0x20
    run_cmd(2'b11, '0, '0, 0);
    run_cmd(2'b00, 4'd3, 32'h20, 0);
    chk("first_in_tid", 32'(in_tid), 3);
    chk("first_info", 32'(parallel_data), 32'h20);

    // fill to DEPTH then one more enqueue
    while (exp_q.size() < DEPTH)
      run_cmd(2'b00, TID_W'($urandom()), INFO_W'($urandom()), 0);
    chk("fill_full", 32'(full), 1);
    run_cmd(2'b00, 4'hA, 32'hDEAD, 0);
    chk("overfill_count", 32'(count), DEPTH);

    // drain with random dispatch latency
    while (exp_q.size() > 0)
      run_cmd(2'b01, '0, '0, $urandom_range(0, 3));

    // single entry tid=5, dispatch held off 4 cycles
    run_cmd(2'b00, 4'd5, 32'h55, 0);
    run_cmd(2'b01, '0, '0, 4);
    chk("single_empty", 32'(empty), 1);

    // dequeue on empty, then block/activate/block incl. redundant ones
    run_cmd(2'b01, '0, '0, 0);
    run_cmd(2'b10, '0, '0, 0);
    run_cmd(2'b11, '0, '0, 0);
    run_cmd(2'b11, '0, '0, 0);
    run_cmd(2'b10, '0, '0, 0);
    run_cmd(2'b10, '0, '0, 0);

    // random traffic
    for (int i = 0; i < 120; i++) begin
      r  = $urandom_range(0, 9);
      op = (r < 5) ? 2'b00 : (r < 9) ? 2'b01 : 2'($urandom_range(2, 3));
      run_cmd(op, TID_W'($urandom()), INFO_W'($urandom()), $urandom_range(0, 2));
    end

    // reset asserted while a dispatch is pending
    if (exp_q.size() == 0) run_cmd(2'b00, 4'd9, 32'h99, 0);
    head_tid  = exp_q[0];
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_disp", 32'(disp_valid), 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_disp_valid", 32'(disp_valid), 0);
    chk("async_count", 32'(count), 0);
    chk("async_blk", 32'(que_blk), 1);
    chk("async_act", 32'(que_act), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'({enqueue, dequeue, remove, err, disp_valid}), 0);
      chk("post_rst_ready", 32'(cmd_ready), 1);
    end
    run_cmd(2'b00, 4'd7, 32'h77, 0);
    run_cmd(2'b01, '0, '0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_task_queue_ctrl.md
SR_TASK_QUEUE_CTRL -- requirements
Module: sr_task_queue_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, number of task-queue cells driven (legal 2..16).
REQ-002 Parameter TID_W, default 4, task-id width.
REQ-003 Parameter INFO_W, default 32, schedule-info width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  controller can accept a command.
REQ-008 cmd_op  input  2  00 enqueue, 01 dequeue, 10 block queue, 11 activate queue.
REQ-009 cmd_tid  input  TID_W  task id for enqueue.
REQ-010 cmd_info  input  INFO_W  schedule info for enqueue.
REQ-011 head_tid  input  TID_W  out_tid of head cell.
REQ-012 enqueue, dequeue, remove  output  1 each  one-cycle strobes to all cells.
REQ-013 que_act, que_blk  output  1 each  queue-state levels to all cells.
REQ-014 in_tid  output  TID_W; parallel_data  output  INFO_W  enqueue payload to cells.
REQ-015 disp_valid  output  1; disp_ready  input  1; disp_tid  output  TID_W  dispatch handshake.
REQ-016 count  output  $clog2(DEPTH+1); full, empty  output  1; err  output  1 one-cycle error pulse.

Function
REQ-017 FSM states IDLE, EXEC, SETTLE, DISP; cmd_ready SHALL be 1 only in IDLE.
REQ-018 Command accepted on edge where cmd_valid&&cmd_ready; IDLE->EXEC.
REQ-019 EXEC lasts one cycle: strobe for accepted op high, then EXEC->SETTLE (one cycle, for registered cell update), SETTLE->IDLE, except dequeue.
REQ-020 Enqueue: in_tid/parallel_data registered from cmd_tid/cmd_info at accept edge and held until next accepted enqueue; enqueue=1 in EXEC; count+1 at EXEC->SETTLE edge.
REQ-021 Enqueue when full: no strobe, count unchanged, err=1 in EXEC cycle.
REQ-022 Dequeue: disp_tid registered from head_tid at accept edge; dequeue=1 in EXEC; count-1; EXEC->DISP; disp_valid=1 throughout DISP.
REQ-023 DISP->IDLE on edge with disp_ready=1; disp_valid falls same edge; disp_tid held stable while disp_valid=1.
REQ-024 Dequeue that takes count 1->0: remove=1 in the same EXEC cycle as dequeue.
REQ-025 Dequeue when empty: no strobe, no dispatch, err=1 in EXEC, EXEC->SETTLE.
REQ-026 Block: que_blk<=1, que_act<=0 at EXEC edge; activate: que_act<=1, que_blk<=0; never both 1.
REQ-027 Block/activate when already in that state: no error, levels unchanged.
REQ-028 full = (count==DEPTH); empty = (count==0); combinational from count.
REQ-029 count never wraps; enqueue and dequeue cannot occur in same cycle (single-command FSM).
REQ-030 Command inputs ignored outside IDLE; disp_ready ignored outside DISP.
REQ-031 Throughput: one command per 3 cycles; dequeue 3 cycles plus dispatch wait.

Reset
REQ-032 While rst=1: state IDLE, count=0, enqueue/dequeue/remove/err/disp_valid=0, que_act=0, que_blk=1, in_tid/disp_tid=0, parallel_data=0.
REQ-033 rst asserted mid-operation (any state) aborts it; pending dispatch discarded; no strobe issued after rst deasserts until new command.
REQ-034 cmd_ready=1 on first rising edge after rst deasserts.

Verification
REQ-035 Reset, activate, enqueue tid=3 info=0x20 -> enqueue pulse 1 cycle, in_tid=3, parallel_data=0x20, count=1, que_act=1, que_blk=0.
REQ-036 Fill DEPTH=8 enqueues then 9th enqueue -> full=1, err pulse, no enqueue strobe, count=8.
REQ-037 count=1, head_tid=5, dequeue with disp_ready low 4 cycles -> dequeue+remove same cycle, disp_valid held, disp_tid=5, cmd_ready=0 until disp_ready, count=0, empty=1.
REQ-038 Dequeue when empty -> err pulse, no dequeue/remove strobe, disp_valid stays 0, cmd_ready back after 3 cycles.
REQ-039 Block then activate then block -> que_blk/que_act toggle exclusively, never both 1.
REQ-040 rst asserted during DISP -> disp_valid=0, count=0, que_blk=1 immediately (asynchronous).
